// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One shared hex decoder, per-slot dead-time, frame-synchronous double buffering.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned DEAD_CYCLES  = 2000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  output logic                    upd_pending,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blk_cnt_q, blk_cnt_d;
  logic                    blk_off_q, blk_off_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic                    upd_q, upd_d;
  logic                    ft_q, ft_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cath_q, cath_d;

  logic       frame_end;
  logic       xfer;
  logic       dark;
  logic [3:0] cur_dig;
  logic [6:0] seg;

  assign frame_end = en && (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
  // While disabled there is no frame boundary to wait for, so pending data moves across at once.
  assign xfer      = upd_q && (frame_end || !en);

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    blk_cnt_d    = blk_cnt_q;
    blk_off_d    = blk_off_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_blink_d = pend_blink_q;
    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    act_blink_d  = act_blink_q;
    upd_d        = upd_q;
    ft_d         = frame_end;

    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (frame_end) begin
      if (blk_cnt_q == BLK_MAX) begin
        blk_cnt_d = '0;
        blk_off_d = ~blk_off_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end

    if (xfer) begin
      act_dig_d   = pend_dig_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      act_blink_d = pend_blink_q;
    end

    // A load coinciding with a transfer refills pending, so the flag stays set.
    if (load) begin
      pend_dig_d   = digits_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      pend_blink_d = blink_in;
      upd_d        = 1'b1;
    end else if (xfer) begin
      upd_d = 1'b0;
    end

    cur_dig = act_dig_q[{idx_q, 2'b00} +: 4];
    case (cur_dig)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase

    dark = (cnt_q < DEAD) || !en || act_blank_q[idx_q]
           || (act_blink_q[idx_q] && blk_off_q);
    if (dark) begin
      anode_d = '1;
      cath_d  = '1;
    end else begin
      anode_d = ~(NUM_DIGITS'(1) << idx_q);
      cath_d  = ~{act_dp_q[idx_q], seg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      blk_cnt_q    <= '0;
      blk_off_q    <= 1'b0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_blink_q <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      act_blink_q  <= '0;
      upd_q        <= 1'b0;
      ft_q         <= 1'b0;
      anode_q      <= '1;
      cath_q       <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_cnt_q    <= blk_cnt_d;
      blk_off_q    <= blk_off_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_blink_q <= pend_blink_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      act_blink_q  <= act_blink_d;
      upd_q        <= upd_d;
      ft_q         <= ft_d;
      anode_q      <= anode_d;
      cath_q       <= cath_d;
    end
  end

  assign upd_pending = upd_q;
  assign frame_tick  = ft_q;
  assign anode       = anode_q;
  assign cathode     = cath_q;

endmodule
